// File: rtl/sb_rx_pkg.sv
// Shared constants, header field positions and decode helpers for the
// sideband receive path.
package sb_rx_pkg;

  localparam logic [63:0] SB_CLK_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

  localparam logic [4:0] OP_CPL_DATA   = 5'b11001;
  localparam logic [4:0] OP_MSG_DATA   = 5'b11011;
  localparam logic [4:0] OP_CPL_NODATA = 5'b10000;
  localparam logic [4:0] OP_MSG_NODATA = 5'b10010;

  localparam int HDR_OP_LSB  = 0;
  localparam int HDR_OP_MSB  = 4;
  localparam int HDR_MSG_LSB = 14;
  localparam int HDR_MSG_MSB = 21;
  localparam int HDR_CP_BIT  = 62;
  localparam int HDR_DP_BIT  = 63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOCKED,
    ST_WAIT_DATA
  } sb_rx_state_t;

  function automatic logic sb_is_data_op(input logic [4:0] op);
    return (op == OP_CPL_DATA) || (op == OP_MSG_DATA);
  endfunction

  function automatic logic sb_is_nodata_op(input logic [4:0] op);
    return (op == OP_CPL_NODATA) || (op == OP_MSG_NODATA);
  endfunction

  // Completions always answer a request; messages only when msgcode[0] is set.
  function automatic logic sb_is_rsp(input logic [4:0] op, input logic msg_lsb);
    return (op == OP_CPL_DATA) || (op == OP_CPL_NODATA) ||
           (((op == OP_MSG_DATA) || (op == OP_MSG_NODATA)) && msg_lsb);
  endfunction

  function automatic logic sb_cp_calc(input logic [61:0] hdr_lo);
    return ^hdr_lo;
  endfunction

endpackage

// File: rtl/sb_rx_pattern_det.sv
// Counts consecutive sideband clock-pattern words during the hunt and holds
// the sticky lock flag until the hunt is cancelled.
module sb_rx_pattern_det
  import sb_rx_pkg::*;
#(
  parameter int MATCH_CNT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_hunt,
  input  logic        i_valid,
  input  logic [63:0] i_data,
  output logic        o_match_done,
  output logic        o_lock
);

  logic [3:0] lane_match;
  logic [3:0] cnt_reg, cnt_next;
  logic       lock_reg, lock_next;
  logic       word_match;
  logic [3:0] cnt_inc;

  // Split the 64-bit compare into four 16-bit lanes to keep the compare tree shallow.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_match[gi] = (i_data[gi*16 +: 16] == SB_CLK_PATTERN[gi*16 +: 16]);
    end
  endgenerate

  assign word_match   = &lane_match;
  assign cnt_inc      = cnt_reg + 4'd1;
  assign o_match_done = i_hunt && i_valid && word_match && (cnt_inc == 4'(MATCH_CNT));
  assign o_lock       = lock_reg;

  always_comb begin
    cnt_next  = cnt_reg;
    lock_next = lock_reg;
    if (i_clear) begin
      cnt_next  = 4'd0;
      lock_next = 1'b0;
    end else if (i_hunt && i_valid) begin
      if (!word_match) begin
        cnt_next = 4'd0;
      end else if (o_match_done) begin
        cnt_next  = 4'd0;
        lock_next = 1'b1;
      end else begin
        cnt_next = cnt_inc;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg  <= 4'd0;
      lock_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      lock_reg <= lock_next;
    end
  end

endmodule

// File: rtl/sb_rx_packet_decoder.sv
// Sideband RX: pattern lock during SBINIT, then header/data framing, parity
// and opcode checks, and packet delivery with a response-delivered pulse.
module sb_rx_packet_decoder
  import sb_rx_pkg::*;
#(
  parameter int PATTERN_MATCH_CNT = 2,
  parameter int DATA_WAIT_MAX     = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start_detect,
  input  logic        i_deser_valid,
  input  logic [63:0] i_deser_data,
  output logic        o_rx_sb_pattern_samp_done,
  output logic        o_rx_sb_rsp_delivered,
  output logic        o_pkt_valid,
  output logic [63:0] o_pkt_hdr,
  output logic [63:0] o_pkt_data,
  output logic        o_pkt_has_data,
  output logic        o_parity_err,
  output logic        o_opcode_err,
  output logic        o_framing_err
);

  localparam int WCW = $clog2(DATA_WAIT_MAX + 1);

  sb_rx_state_t   state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next, wait_inc;
  logic [63:0]    hdr_reg, hdr_next;
  logic           pkt_valid_reg, pkt_valid_next;
  logic           rsp_reg, rsp_next;
  logic [63:0]    pkt_hdr_reg, pkt_hdr_next;
  logic [63:0]    pkt_data_reg, pkt_data_next;
  logic           has_data_reg, has_data_next;
  logic           par_err_reg, par_err_next;
  logic           op_err_reg, op_err_next;
  logic           frm_err_reg, frm_err_next;

  logic           match_done;
  logic [4:0]     word_op;
  logic           word_filler, word_cp_ok, word_known, word_is_data;
  logic           data_dp_ok;

  sb_rx_pattern_det #(
    .MATCH_CNT (PATTERN_MATCH_CNT)
  ) u_pattern_det (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (!i_start_detect),
    .i_hunt       (state_reg == ST_HUNT),
    .i_valid      (i_deser_valid),
    .i_data       (i_deser_data),
    .o_match_done (match_done),
    .o_lock       (o_rx_sb_pattern_samp_done)
  );

  assign word_op      = i_deser_data[HDR_OP_MSB:HDR_OP_LSB];
  assign word_filler  = (i_deser_data == SB_CLK_PATTERN) || (i_deser_data == 64'd0);
  assign word_cp_ok   = (i_deser_data[HDR_CP_BIT] == sb_cp_calc(i_deser_data[HDR_CP_BIT-1:0]));
  assign word_is_data = sb_is_data_op(word_op);
  assign word_known   = word_is_data || sb_is_nodata_op(word_op);
  assign data_dp_ok   = (hdr_reg[HDR_DP_BIT] == ^i_deser_data);
  assign wait_inc     = wait_cnt_reg + WCW'(1);

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    hdr_next       = hdr_reg;
    pkt_valid_next = 1'b0;
    rsp_next       = 1'b0;
    par_err_next   = 1'b0;
    op_err_next    = 1'b0;
    frm_err_next   = 1'b0;
    pkt_hdr_next   = pkt_hdr_reg;
    pkt_data_next  = pkt_data_reg;
    has_data_next  = has_data_reg;

    if (!i_start_detect) begin
      // Abort silently: drop any partial packet, delivered fields stay visible.
      state_next    = ST_IDLE;
      wait_cnt_next = '0;
      hdr_next      = 64'd0;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_HUNT;

        ST_HUNT: if (match_done) state_next = ST_LOCKED;

        ST_LOCKED: begin
          if (i_deser_valid && !word_filler) begin
            if (!word_cp_ok || !word_known) begin
              par_err_next = !word_cp_ok;
              op_err_next  = !word_known;
            end else if (word_is_data) begin
              hdr_next      = i_deser_data;
              wait_cnt_next = '0;
              state_next    = ST_WAIT_DATA;
            end else if (i_deser_data[HDR_DP_BIT]) begin
              par_err_next = 1'b1;
            end else begin
              pkt_valid_next = 1'b1;
              rsp_next       = sb_is_rsp(word_op, i_deser_data[HDR_MSG_LSB]);
              pkt_hdr_next   = i_deser_data;
              pkt_data_next  = 64'd0;
              has_data_next  = 1'b0;
            end
          end
        end

        ST_WAIT_DATA: begin
          if (i_deser_valid) begin
            state_next = ST_LOCKED;
            if (data_dp_ok) begin
              pkt_valid_next = 1'b1;
              rsp_next       = sb_is_rsp(hdr_reg[HDR_OP_MSB:HDR_OP_LSB], hdr_reg[HDR_MSG_LSB]);
              pkt_hdr_next   = hdr_reg;
              pkt_data_next  = i_deser_data;
              has_data_next  = 1'b1;
            end else begin
              par_err_next = 1'b1;
            end
          end else if (wait_inc == WCW'(DATA_WAIT_MAX)) begin
            frm_err_next  = 1'b1;
            wait_cnt_next = '0;
            state_next    = ST_LOCKED;
          end else begin
            wait_cnt_next = wait_inc;
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= '0;
      hdr_reg       <= 64'd0;
      pkt_valid_reg <= 1'b0;
      rsp_reg       <= 1'b0;
      pkt_hdr_reg   <= 64'd0;
      pkt_data_reg  <= 64'd0;
      has_data_reg  <= 1'b0;
      par_err_reg   <= 1'b0;
      op_err_reg    <= 1'b0;
      frm_err_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      hdr_reg       <= hdr_next;
      pkt_valid_reg <= pkt_valid_next;
      rsp_reg       <= rsp_next;
      pkt_hdr_reg   <= pkt_hdr_next;
      pkt_data_reg  <= pkt_data_next;
      has_data_reg  <= has_data_next;
      par_err_reg   <= par_err_next;
      op_err_reg    <= op_err_next;
      frm_err_reg   <= frm_err_next;
    end
  end

  assign o_rx_sb_rsp_delivered = rsp_reg;
  assign o_pkt_valid           = pkt_valid_reg;
  assign o_pkt_hdr             = pkt_hdr_reg;
  assign o_pkt_data            = pkt_data_reg;
  assign o_pkt_has_data        = has_data_reg;
  assign o_parity_err          = par_err_reg;
  assign o_opcode_err          = op_err_reg;
  assign o_framing_err         = frm_err_reg;

endmodule

// File: tb/tb_sb_rx_packet_decoder.sv
// Directed plus randomized stimulus for sb_rx_packet_decoder, checked every
// cycle against a transaction-level reference model.
module tb_sb_rx_packet_decoder;

  localparam int          PMC = 2;
  localparam int          DWM = 8;
  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [4:0]  C_DATA = 5'b11001, M_DATA = 5'b11011;
  localparam logic [4:0]  C_NODATA = 5'b10000, M_NODATA = 5'b10010;
  localparam int          MD_IDLE = 0, MD_HUNT = 1, MD_LOCK = 2, MD_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd = 1'b0;
  logic        dv = 1'b0;
  logic [63:0] dd = 64'd0;

  logic        samp, rsp, pvalid, has_data, par_err, op_err, frm_err;
  logic [63:0] phdr, pdata;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model
  int          m_mode, m_cnt, m_gap;
  logic [63:0] m_pend;
  logic        e_samp, e_rsp, e_valid, e_has, e_par, e_op, e_frm;
  logic [63:0] e_hdr, e_data;

  always #5 clk = ~clk;

  sb_rx_packet_decoder #(
    .PATTERN_MATCH_CNT (PMC),
    .DATA_WAIT_MAX     (DWM)
  ) dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_start_detect            (sd),
    .i_deser_valid             (dv),
    .i_deser_data              (dd),
    .o_rx_sb_pattern_samp_done (samp),
    .o_rx_sb_rsp_delivered     (rsp),
    .o_pkt_valid               (pvalid),
    .o_pkt_hdr                 (phdr),
    .o_pkt_data                (pdata),
    .o_pkt_has_data            (has_data),
    .o_parity_err              (par_err),
    .o_opcode_err              (op_err),
    .o_framing_err             (frm_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic odd62(input logic [63:0] h);
    int n = 0;
    for (int i = 0; i < 62; i++) n += int'(h[i]);
    return (n % 2) == 1;
  endfunction

  function automatic logic dpar(input logic [63:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  function automatic logic m_is_rsp(input logic [63:0] h);
    if (h[4:0] == C_DATA || h[4:0] == C_NODATA) return 1'b1;
    if (h[4:0] == M_DATA || h[4:0] == M_NODATA) return h[14];
    return 1'b0;
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic [7:0] mc,
                                         input logic dp, input logic cp_good);
    logic [63:0] h;
    h        = {$urandom, $urandom};
    h[4:0]   = op;
    h[21:14] = mc;
    h[63]    = dp;
    h[62]    = odd62(h) ^ !cp_good;
    return h;
  endfunction

  task automatic model_reset();
    m_mode = MD_IDLE; m_cnt = 0; m_gap = 0; m_pend = 64'd0;
    e_samp = 0; e_rsp = 0; e_valid = 0; e_has = 0; e_par = 0; e_op = 0; e_frm = 0;
    e_hdr = 64'd0; e_data = 64'd0;
  endtask

  task automatic deliver(input logic [63:0] h, input logic [63:0] d, input logic with_data);
    e_valid = 1; e_rsp = m_is_rsp(h); e_hdr = h; e_data = d; e_has = with_data;
    $display("[TB] cyc=%0d packet hdr=%h data=%h has_data=%0b rsp=%0b", cyc, h, d, with_data, e_rsp);
  endtask

  task automatic model_step(input logic s, input logic v, input logic [63:0] d);
    logic cp_bad, unk;
    e_valid = 0; e_rsp = 0; e_par = 0; e_op = 0; e_frm = 0;
    cp_bad = (d[62] != odd62(d));
    unk    = !(d[4:0] == C_DATA || d[4:0] == M_DATA || d[4:0] == C_NODATA || d[4:0] == M_NODATA);
    if (!s) begin
      m_mode = MD_IDLE; m_cnt = 0; e_samp = 0;
    end else begin
      case (m_mode)
        MD_IDLE: m_mode = MD_HUNT;
        MD_HUNT: if (v) begin
          if (d == PAT) begin
            m_cnt++;
            if (m_cnt == PMC) begin e_samp = 1; m_mode = MD_LOCK; m_cnt = 0; end
          end else m_cnt = 0;
        end
        MD_LOCK: if (v && d != PAT && d != 64'd0) begin
          if (cp_bad || unk) begin e_par = cp_bad; e_op = unk; end
          else if (d[4:0] == C_DATA || d[4:0] == M_DATA) begin m_pend = d; m_gap = 0; m_mode = MD_WAIT; end
          else if (d[63]) e_par = 1;
          else deliver(d, 64'd0, 1'b0);
        end
        default: begin
          if (v) begin
            m_mode = MD_LOCK;
            if (dpar(d) == m_pend[63]) deliver(m_pend, d, 1'b1);
            else e_par = 1;
          end else begin
            m_gap++;
            if (m_gap == DWM) begin e_frm = 1; m_mode = MD_LOCK; end
          end
        end
      endcase
    end
  endtask

  task automatic chk_all();
    chk("samp_done", 64'(samp), 64'(e_samp));
    chk("rsp_delivered", 64'(rsp), 64'(e_rsp));
    chk("pkt_valid", 64'(pvalid), 64'(e_valid));
    chk("pkt_hdr", phdr, e_hdr);
    chk("pkt_data", pdata, e_data);
    chk("pkt_has_data", 64'(has_data), 64'(e_has));
    chk("parity_err", 64'(par_err), 64'(e_par));
    chk("opcode_err", 64'(op_err), 64'(e_op));
    chk("framing_err", 64'(frm_err), 64'(e_frm));
  endtask

  task automatic cycle(input logic s, input logic v, input logic [63:0] d);
    sd = s; dv = v; dd = d;
    @(posedge clk);
    #1;
    cyc++;
    model_step(s, v, d);
    chk_all();
  endtask

  initial begin
    logic [63:0] h, w;
    logic [4:0]  ops [4];
    logic [4:0]  op;
    logic        s, v;
    ops[0] = C_DATA; ops[1] = M_DATA; ops[2] = C_NODATA; ops[3] = M_NODATA;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;

    // lock, with an intervening non-pattern word restarting the count
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, PAT);
    cycle(1, 1, 64'h1234);
    cycle(1, 1, PAT);
    chk("samp_before_4th", 64'(samp), 64'd0);
    cycle(1, 1, PAT);
    chk("samp_after_4th", 64'(samp), 64'd1);

    // no-data response after pattern iterations
    repeat (6) cycle(1, 1, PAT);
    cycle(1, 1, mk_hdr(M_NODATA, 8'h01, 1'b0, 1'b1));
    chk("nodata_valid", 64'(pvalid), 64'd1);
    chk("nodata_rsp", 64'(rsp), 64'd1);

    // data packet with a 3-cycle gap
    cycle(1, 1, mk_hdr(C_DATA, 8'h00, dpar(64'hDEAD_BEEF_0000_0001), 1'b1));
    repeat (3) cycle(1, 0, 0);
    cycle(1, 1, 64'hDEAD_BEEF_0000_0001);
    chk("data_word", pdata, 64'hDEAD_BEEF_0000_0001);
    chk("data_has", 64'(has_data), 64'd1);

    // header bit 7 flipped
    h = mk_hdr(M_NODATA, 8'h02, 1'b0, 1'b1);
    h[7] = ~h[7];
    cycle(1, 1, h);
    chk("flip7_par", 64'(par_err), 64'd1);
    chk("flip7_valid", 64'(pvalid), 64'd0);

    // wrong dp on data word
    cycle(1, 1, mk_hdr(M_DATA, 8'h03, 1'b0, 1'b1));
    cycle(1, 1, 64'h1);
    chk("bad_dp", 64'(par_err), 64'd1);

    // bad cp and unknown opcode together
    cycle(1, 1, mk_hdr(5'b00111, 8'h00, 1'b0, 1'b0));
    chk("both_err_op", 64'(op_err), 64'd1);

    // dp set on a no-data opcode
    cycle(1, 1, mk_hdr(C_NODATA, 8'h00, 1'b1, 1'b1));

    // framing timeout then normal decode
    cycle(1, 1, mk_hdr(M_DATA, 8'h05, 1'b0, 1'b1));
    repeat (DWM) cycle(1, 0, 0);
    chk("framing", 64'(frm_err), 64'd1);
    cycle(1, 1, mk_hdr(C_NODATA, 8'h00, 1'b0, 1'b1));
    chk("after_framing_valid", 64'(pvalid), 64'd1);

    // data pattern value accepted as data word
    cycle(1, 1, mk_hdr(M_DATA, 8'h00, dpar(PAT), 1'b1));
    cycle(1, 1, PAT);

    // abort during WAIT_DATA, then fresh hunt
    cycle(1, 1, mk_hdr(C_DATA, 8'h00, 1'b0, 1'b1));
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    chk("abort_samp", 64'(samp), 64'd0);
    cycle(1, 0, 0);
    cycle(1, 1, mk_hdr(C_NODATA, 8'h00, 1'b0, 1'b1));
    chk("hunt_ignores_hdr", 64'(pvalid), 64'd0);
    cycle(1, 1, PAT);
    cycle(1, 1, PAT);

    // asynchronous reset mid-packet
    cycle(1, 1, mk_hdr(M_DATA, 8'h01, 1'b0, 1'b1));
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_all();
    rst_n = 1'b1;
    cycle(1, 0, 0);
    cycle(1, 1, PAT);
    cycle(1, 1, PAT);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 199) != 0);
      v = ($urandom_range(0, 1) == 1);
      op = ops[$urandom_range(0, 3)];
      case ($urandom_range(0, 9))
        0, 1, 2: w = PAT;
        3:       w = 64'd0;
        4, 5, 6: w = mk_hdr(op, 8'($urandom), (op[0] ? 1'($urandom) : ($urandom_range(0, 7) == 0)), 1'b1);
        7:       w = mk_hdr(op, 8'($urandom), 1'b0, 1'b0);
        8:       w = mk_hdr(5'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'($urandom));
        default: w = {$urandom, $urandom};
      endcase
      cycle(s, v, w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sb_rx_packet_decoder.md
Name: sb_rx_packet_decoder

Overview:
- Receive-side counterpart of the sideband TX encoder path; consumes 64-bit deserialized words.
- During SBINIT it hunts for the sideband clock pattern and raises the pattern-sampled indication that the TX pattern generator waits on.
- After lock it frames header and data words, checks control/data parity and decodes the opcode.
- Delivers packets to the LTSM/message layer and raises the response-delivered pulse that stops the TX timeout counter.

Parameters:
- PATTERN_MATCH_CNT, 2, consecutive 64'hAAAA_AAAA_AAAA_AAAA words required to declare lock (1..15)
- DATA_WAIT_MAX, 8, maximum cycles allowed between a data-bearing header and its data word

Ports:
- i_clk  input  1  single clock
- i_rst_n  input  1  asynchronous active-low reset
- i_start_detect  input  1  level from LTSM; 1 = SBINIT pattern hunt enabled, 0 = clears lock and returns the block to IDLE
- i_deser_valid  input  1  one-cycle strobe; i_deser_data holds a new word
- i_deser_data  input  64  deserialized word; header phase0 = [31:0], phase1 = [63:32]
- o_rx_sb_pattern_samp_done  output  1  sticky level; pattern locked
- o_rx_sb_rsp_delivered  output  1  one-cycle pulse; valid response packet received
- o_pkt_valid  output  1  one-cycle pulse; o_pkt_* fields are valid
- o_pkt_hdr  output  64  received header
- o_pkt_data  output  64  received data word (0 when the packet carries no data)
- o_pkt_has_data  output  1  packet carried a data word
- o_parity_err  output  1  pulse; cp or dp mismatch, packet dropped
- o_opcode_err  output  1  pulse; unknown opcode, header dropped
- o_framing_err  output  1  pulse; data word not received within DATA_WAIT_MAX

Behaviour:
- Reset: state IDLE; all outputs 0; match counter 0; wait counter 0; header register 0.
- All outputs are registered.
- Header fields: opcode = hdr[4:0], msgcode = hdr[21:14], cp = hdr[62], dp = hdr[63].
- Parity rules:
  - cp must equal ^hdr[61:0].
  - dp must equal ^data[63:0] for data opcodes.
  - dp must be 0 for no-data opcodes.
- Opcode classes:
  - Data opcodes: CPL_DATA 5'b11001, MSG_DATA 5'b11011.
  - No-data opcodes: CPL_NODATA 5'b10000, MSG_NODATA 5'b10010.
  - Response = either completion opcode, or a message opcode with msgcode[0]=1.
- FSM states: IDLE, HUNT, LOCKED, WAIT_DATA.
- IDLE: go to HUNT when i_start_detect=1.
- HUNT, per valid word:
  - Word == PATTERN: counter+1.
  - Any other word: counter reset to 0.
  - When the counter reaches PATTERN_MATCH_CNT, go to LOCKED and set o_rx_sb_pattern_samp_done the next cycle.
- LOCKED, per valid word:
  - PATTERN word or all-zero word: discard silently (the partner keeps sending pattern iterations after lock).
  - Otherwise the word is a header:
    - cp bad: o_parity_err, stay in LOCKED.
    - Opcode unknown: o_opcode_err, stay in LOCKED.
    - Both checks apply together: cp bad and opcode unknown pulses both errors in the same cycle.
    - No-data opcode with dp bad: o_parity_err.
    - No-data opcode with dp good: o_pkt_valid next cycle, o_pkt_has_data=0.
    - Data opcode: latch header, clear wait counter, go to WAIT_DATA.
- WAIT_DATA:
  - Each cycle without i_deser_valid: wait counter+1.
  - Counter reaching DATA_WAIT_MAX: o_framing_err, return to LOCKED.
  - Valid word arrives: it is the data word, whatever its value (including the pattern value or 0).
    - dp matches: o_pkt_valid, o_pkt_has_data=1, return to LOCKED.
    - dp mismatch: o_parity_err, return to LOCKED.
- Latency: no-data packet → o_pkt_valid 1 cycle after header strobe; data packet → o_pkt_valid 1 cycle after data strobe.
- o_rx_sb_rsp_delivered pulses in the same cycle as o_pkt_valid when the packet is a response.
- o_pkt_hdr and o_pkt_data hold their values until the next o_pkt_valid.
- i_start_detect falling in any state: next cycle IDLE, o_rx_sb_pattern_samp_done=0, counters cleared, any partial packet discarded with no error pulse.
- Reset mid-packet: same as the reset values above.
- At most one of o_pkt_valid / o_framing_err pulses per cycle; errors and o_pkt_valid are mutually exclusive.

Decomposition:
- Package sb_rx_pkg holds:
  - SB_CLK_PATTERN
  - opcode localparams
  - header field bit positions
  - function sb_is_data_op
  - function sb_is_rsp
  - function sb_cp_calc
- Sub-module sb_rx_pattern_det: HUNT match counter and lock flag; instantiated once.

Test Plan:
- Lock: i_start_detect=1; drive 0xAAAA..., 0x1234, 0xAAAA..., 0xAAAA... → samp_done rises exactly 1 cycle after the 4th word (the intervening word resets the count).
- No-data response: after lock, send 6 pattern words, then a MSG_NODATA header with msgcode=8'h01 and correct cp → one o_pkt_valid plus o_rx_sb_rsp_delivered, 1 cycle after the header; the pattern words produce no output.
- Data packet: CPL_DATA header, gap of 3 cycles, then data 64'hDEAD_BEEF_0000_0001 with correct dp → o_pkt_valid, o_pkt_has_data=1, o_pkt_data matches the data word.
- Parity:
  - Flip hdr bit 7 → o_parity_err only, no o_pkt_valid.
  - Wrong dp on the data word → o_parity_err.
- Framing: MSG_DATA header followed by no valid words for DATA_WAIT_MAX=8 cycles → o_framing_err on the cycle the counter reaches 8; the next header is decoded normally.
- Abort: drop i_start_detect while in WAIT_DATA → IDLE, samp_done=0, no error pulse; reassert → a fresh hunt is required.
